// File: rtl/ones_sm_pkg.sv
// ---------------------------------------------------------------------------
// ones_sm_pkg
// Shared definitions for the ones-count family of engines.
//   - state_size / state_t : controller state encoding. The counting engine's
//                            controller uses the same encoding.
//   - DEF_WORD_SIZE        : default width of the generated word.
//   - DEF_COUNTER_SIZE     : default width of the requested ones count.
// ---------------------------------------------------------------------------
package ones_sm_pkg;

  localparam int unsigned state_size       = 2;
  localparam int unsigned DEF_WORD_SIZE    = 4;
  localparam int unsigned DEF_COUNTER_SIZE = 3;

  // Code 3 is unused. The controller treats it as a recovery case.
  typedef enum logic [state_size-1:0] {
    S_idle    = 2'd0,
    S_filling = 2'd1,
    S_waiting = 2'd2
  } state_t;

endpackage : ones_sm_pkg

// File: rtl/ones_pattern_datapath.sv
// ---------------------------------------------------------------------------
// ones_pattern_datapath
// Holds the thermometer-code shift register and the down-counter of ones
// still to be inserted. The requested count is clamped to word_size when it
// is loaded.
// Ports:
//   clk         : clock
//   reset       : asynchronous active-low reset
//   i_load      : capture the clamped i_bit_count and clear the word
//   i_shift     : insert one '1' at the LSB while ones remain
//   i_clear     : clear the word and the counter (controller recovery)
//   i_bit_count : requested number of ones
//   o_rem_le_1  : at most one shift remains (the fill ends on this edge)
//   o_data      : generated pattern
// ---------------------------------------------------------------------------
module ones_pattern_datapath
  import ones_sm_pkg::*;
#(
  parameter int unsigned word_size    = DEF_WORD_SIZE,
  parameter int unsigned counter_size = DEF_COUNTER_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic                    i_shift,
  input  logic                    i_clear,
  input  logic [counter_size-1:0] i_bit_count,
  output logic                    o_rem_le_1,
  output logic [word_size-1:0]    o_data
);

  // The clamp compares at counter_size+1 bits. That width keeps the compare
  // correct when word_size == 2**counter_size. A word wider than the count
  // range can never be exceeded, so the limit saturates at 2**counter_size
  // to stay representable in the compare width.
  localparam int unsigned COUNT_RANGE = 1 << counter_size;
  localparam int unsigned WS_SAT      = (word_size > COUNT_RANGE) ? COUNT_RANGE : word_size;
  localparam logic [counter_size:0] WS_CMP = WS_SAT[counter_size:0];

  logic [counter_size-1:0] r_remaining;
  logic [word_size-1:0]    r_data;
  logic [counter_size:0]   w_req;
  logic [counter_size:0]   w_clamped;
  logic [counter_size-1:0] w_load_val;

  assign w_req     = {1'b0, i_bit_count};
  assign w_clamped = (w_req > WS_CMP) ? WS_CMP : w_req;
  // The clamped value always fits in counter_size bits: either it is
  // i_bit_count itself, or it is a word_size below 2**counter_size.
  assign w_load_val = w_clamped[counter_size-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_remaining <= '0;
      r_data      <= '0;
    end else if (i_clear) begin
      r_remaining <= '0;
      r_data      <= '0;
    end else if (i_load) begin
      r_remaining <= w_load_val;
      r_data      <= '0;
    end else if (i_shift && (r_remaining != '0)) begin
      r_data      <= {r_data[word_size-2:0], 1'b1};
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign o_rem_le_1 = (r_remaining <= counter_size'(1));
  assign o_data     = r_data;

endmodule : ones_pattern_datapath

// File: rtl/ones_pattern_gen_sm.sv
// ---------------------------------------------------------------------------
// ones_pattern_gen_sm
// Builds a word with a requested number of ones packed from the LSB,
// inserting one bit per clock. It uses a start/busy/done handshake.
// Ports:
//   clk       : clock; all state changes happen on posedge
//   reset     : asynchronous active-low reset
//   start     : generation request; accepted while idle or done
//   bit_count : requested ones count; sampled on the accepting edge only
//   data      : generated pattern (registered)
//   busy      : high while filling
//   done      : high while a completed pattern is held on data
// ---------------------------------------------------------------------------
module ones_pattern_gen_sm
  import ones_sm_pkg::*;
#(
  parameter int unsigned word_size    = DEF_WORD_SIZE,
  parameter int unsigned counter_size = DEF_COUNTER_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [counter_size-1:0] bit_count,
  output logic [word_size-1:0]    data,
  output logic                    busy,
  output logic                    done
);

  state_t r_state;
  state_t w_state_next;
  logic   w_load;
  logic   w_shift;
  logic   w_clear;
  logic   w_rem_le_1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_idle: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_filling;
        end
      end
      S_filling: begin
        // start is ignored here, so a request cannot restart a fill.
        w_shift = 1'b1;
        if (w_rem_le_1) begin
          w_state_next = S_waiting;
        end
      end
      S_waiting: begin
        // A restart goes directly back to filling, with no idle cycle.
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_filling;
        end
      end
      default: begin
        w_clear      = 1'b1;
        w_state_next = S_idle;
      end
    endcase
  end

  ones_pattern_datapath #(
    .word_size   (word_size),
    .counter_size(counter_size)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_clear    (w_clear),
    .i_bit_count(bit_count),
    .o_rem_le_1 (w_rem_le_1),
    .o_data     (data)
  );

  assign busy = (r_state == S_filling);
  assign done = (r_state == S_waiting);

endmodule : ones_pattern_gen_sm
